// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU interrupt controller.
//   MPU_DATA_W    : interrupt payload width
//   MPU_DEF_DEPTH : default interrupt queue depth
//   MPU_DEF_GUARD : default guard interval between stall release and MPU re-enable
//   stall_state_t : stall FSM state encoding
package mpu_pkg;

  localparam int MPU_DATA_W    = 64;
  localparam int MPU_DEF_DEPTH = 4;
  localparam int MPU_DEF_GUARD = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_GUARD = 2'd2
  } stall_state_t;

endpackage

// File: rtl/mpu_irq_fifo.sv
// Interrupt payload FIFO for the MPU interrupt controller.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, din       : push request and payload
//   pop             : pop request (ignored while empty)
//   full, empty     : occupancy flags
//   push_acc/pop_acc: push/pop actually performed this cycle
//   count/count_nxt : current and next-cycle entry count
//   head            : head-of-queue payload, zero when empty
module mpu_irq_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic             push_acc,
  output logic             pop_acc,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_nxt,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop frees the slot the same cycle, so a push into a full queue still
  // succeeds when it coincides with an accepted pop.
  assign pop_acc  = pop && !empty;
  assign push_acc = push && (!full || pop_acc);

  assign head = empty ? '0 : mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push_acc, pop_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_acc) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mpu_irq_ctrl.sv
// MPU interrupt controller: queues MPU interrupt payloads for the main
// processor and stalls the MPU while entries are outstanding.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | MPU enabled (mpu_en=1)
//   ST_STALL | MPU stalled, waiting for queue release condition
//   ST_GUARD | MPU still stalled, guard counter running down to re-enable
//
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   mpu_irq/mpu_data : interrupt request and payload from the MPU
//   mpu_en           : MPU run enable
//   cpu_irq          : level interrupt to the processor (masked by cpu_mask)
//   cpu_data         : head-of-queue payload, zero when empty
//   cpu_ack          : pops the head entry
//   pending          : current entry count
//   overflow/ovf_clr : sticky drop flag and its clear pulse
module mpu_irq_ctrl
  import mpu_pkg::*;
#(
  parameter  int DEPTH = MPU_DEF_DEPTH,
  parameter  int HOLD  = 1,
  parameter  int GUARD = MPU_DEF_GUARD,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  mpu_irq,
  input  logic [MPU_DATA_W-1:0] mpu_data,
  output logic                  mpu_en,
  output logic                  cpu_irq,
  output logic [MPU_DATA_W-1:0] cpu_data,
  input  logic                  cpu_ack,
  input  logic                  cpu_mask,
  output logic [CW-1:0]         pending,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  logic          fifo_full;
  logic          fifo_empty;
  logic          push_acc;
  logic          pop_acc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  stall_state_t  state;
  stall_state_t  state_nxt;
  logic [3:0]    gcnt;
  logic [3:0]    gcnt_nxt;
  logic          stall_trig;
  logic          stall_rel;
  logic          drop;

  mpu_irq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MPU_DATA_W)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .push      (mpu_irq),
    .pop       (cpu_ack),
    .din       (mpu_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_acc  (push_acc),
    .pop_acc   (pop_acc),
    .count     (count),
    .count_nxt (count_nxt),
    .head      (cpu_data)
  );

  assign pending = count;
  assign drop    = mpu_irq && !push_acc;

  // Stall is triggered by the accepted push itself; release is judged on the
  // registered count so the guard interval starts after the queue drains.
  assign stall_trig = push_acc && ((HOLD != 0) || (count_nxt == CW'(DEPTH)));
  assign stall_rel  = (HOLD != 0) ? fifo_empty : !fifo_full;

  assign mpu_en = (state == ST_RUN);

  always_comb begin
    state_nxt = state;
    gcnt_nxt  = gcnt;
    case (state)
      ST_RUN: begin
        if (stall_trig) state_nxt = ST_STALL;
      end
      ST_STALL: begin
        if (stall_rel && !stall_trig) begin
          state_nxt = ST_GUARD;
          gcnt_nxt  = 4'(GUARD - 1);
        end
      end
      ST_GUARD: begin
        if (stall_trig) begin
          state_nxt = ST_STALL;
          gcnt_nxt  = '0;
        end else if (gcnt == '0) begin
          state_nxt = ST_RUN;
        end else begin
          gcnt_nxt = gcnt - 4'd1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        gcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= ST_RUN;
      gcnt     <= '0;
      overflow <= 1'b0;
      cpu_irq  <= 1'b0;
    end else begin
      state    <= state_nxt;
      gcnt     <= gcnt_nxt;
      // A new drop wins over a coincident clear.
      overflow <= drop || (overflow && !ovf_clr);
      // Built from the next count so the irq rises with the first entry.
      cpu_irq  <= (count_nxt != '0) && !cpu_mask;
    end
  end

endmodule

// File: tb/tb_mpu_irq_ctrl.sv
module tb_mpu_irq_ctrl;

  localparam int DEPTH = 4;
  localparam int GUARD = 4;
  localparam int PW    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq = 1'b0;
  logic        ack = 1'b0;
  logic        mask = 1'b0;
  logic        clr = 1'b0;
  logic [63:0] data = '0;

  logic          en1, cirq1, ovf1;
  logic [63:0]   cd1;
  logic [PW-1:0] pend1;
  logic          en0, cirq0, ovf0;
  logic [63:0]   cd0;
  logic [PW-1:0] pend0;

  always #5 clk = ~clk;

  mpu_irq_ctrl #(.DEPTH(DEPTH), .HOLD(1), .GUARD(GUARD)) dut_h1 (
    .sys_clk(clk), .sys_rst(rst), .mpu_irq(irq), .mpu_data(data),
    .mpu_en(en1), .cpu_irq(cirq1), .cpu_data(cd1), .cpu_ack(ack),
    .cpu_mask(mask), .pending(pend1), .overflow(ovf1), .ovf_clr(clr)
  );

  mpu_irq_ctrl #(.DEPTH(DEPTH), .HOLD(0), .GUARD(GUARD)) dut_h0 (
    .sys_clk(clk), .sys_rst(rst), .mpu_irq(irq), .mpu_data(data),
    .mpu_en(en0), .cpu_irq(cirq0), .cpu_data(cd0), .cpu_ack(ack),
    .cpu_mask(mask), .pending(pend0), .overflow(ovf0), .ovf_clr(clr)
  );

  typedef struct {
    logic [PW-1:0] pend;
    logic          cirq;
    logic [63:0]   cd;
    logic          ovf;
    logic          en1;
    logic          en0;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: payload queue, sticky flag, and per-HOLD stall view
  // expressed as "stalled" plus the cycle index at which the MPU resumes.
  logic [63:0] mq[$];
  bit          m_ovf;
  bit          stalled[2];
  int          resume_at[2];
  int          k = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: dut=%0h expected=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit i, input logic [63:0] d,
                            input bit a, input bit m, input bit c, output exp_t e);
    int  old;
    bit  pop_ok, push_ok, trig, rel;
    k++;
    if (r) begin
      mq.delete();
      m_ovf = 0;
      for (int h = 0; h < 2; h++) begin
        stalled[h]   = 0;
        resume_at[h] = 0;
      end
    end else begin
      old     = mq.size();
      pop_ok  = a && (old > 0);
      push_ok = i && ((old < DEPTH) || pop_ok);
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back(d);
      if (i && !push_ok) m_ovf = 1;
      else if (c) m_ovf = 0;
      for (int h = 0; h < 2; h++) begin
        trig = push_ok && ((h == 1) || (mq.size() == DEPTH));
        rel  = (h == 1) ? (old == 0) : (old < DEPTH);
        if (!stalled[h] && trig) begin
          stalled[h] = 1;
        end else if (stalled[h] && rel && !trig) begin
          stalled[h]   = 0;
          resume_at[h] = k + GUARD;
        end
      end
    end
    e.pend = PW'(mq.size());
    e.cirq = !r && (mq.size() != 0) && !m;
    e.cd   = (mq.size() != 0) ? mq[0] : 64'd0;
    e.ovf  = m_ovf;
    e.en1  = !stalled[1] && (k >= resume_at[1]);
    e.en0  = !stalled[0] && (k >= resume_at[0]);
  endtask

  task automatic drive(input bit r, input bit i, input logic [63:0] d,
                       input bit a, input bit m, input bit c);
    exp_t e;
    @(negedge clk);
    rst  = r;
    irq  = i;
    data = d;
    ack  = a;
    mask = m;
    clr  = c;
    model_step(r, i, d, a, m, c, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive(0, 0, 64'd0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("h1_pending", 64'(pend1), 64'(e.pend));
        check("h1_cpu_irq", 64'(cirq1), 64'(e.cirq));
        check("h1_cpu_data", cd1, e.cd);
        check("h1_overflow", 64'(ovf1), 64'(e.ovf));
        check("h1_mpu_en", 64'(en1), 64'(e.en1));
        check("h0_pending", 64'(pend0), 64'(e.pend));
        check("h0_cpu_irq", 64'(cirq0), 64'(e.cirq));
        check("h0_cpu_data", cd0, e.cd);
        check("h0_overflow", 64'(ovf0), 64'(e.ovf));
        check("h0_mpu_en", 64'(en0), 64'(e.en0));
      end
    end
  end

  initial begin : stimulus
    drive(1, 0, 64'd0, 0, 0, 0);
    drive(1, 0, 64'd0, 0, 0, 0);
    idle(2);

    // single entry, ack, guard interval
    drive(0, 1, 64'h0123456789ABCDEF, 0, 0, 0);
    idle(2);
    drive(0, 0, 64'd0, 1, 0, 0);
    idle(8);

    // five back-to-back irqs, one dropped, then drain in order
    for (int j = 1; j <= 5; j++) drive(0, 1, 64'(j), 0, 0, 0);
    idle(1);
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 64'd0, 1, 0, 0);
      idle(1);
    end
    idle(8);
    drive(0, 0, 64'd0, 0, 0, 1);

    // full queue with simultaneous push and pop
    for (int j = 0; j < 4; j++) drive(0, 1, 64'h10 + 64'(j), 0, 0, 0);
    drive(0, 1, 64'hAA, 1, 0, 0);
    for (int j = 0; j < 4; j++) drive(0, 0, 64'd0, 1, 0, 0);
    idle(8);

    // drop coincident with clear keeps overflow set
    for (int j = 0; j < 4; j++) drive(0, 1, 64'h20 + 64'(j), 0, 0, 0);
    drive(0, 1, 64'hDEAD, 0, 0, 1);
    drive(0, 0, 64'd0, 0, 0, 1);
    for (int j = 0; j < 4; j++) drive(0, 0, 64'd0, 1, 0, 0);
    idle(8);

    // mask with two pending, release, drain, ack on empty
    drive(0, 1, 64'h31, 0, 0, 0);
    drive(0, 1, 64'h32, 0, 1, 0);
    drive(0, 0, 64'd0, 0, 1, 0);
    drive(0, 0, 64'd0, 0, 1, 0);
    drive(0, 0, 64'd0, 0, 0, 0);
    drive(0, 0, 64'd0, 1, 0, 0);
    drive(0, 0, 64'd0, 1, 0, 0);
    drive(0, 0, 64'd0, 1, 0, 0);
    idle(8);

    // new irq during guard
    drive(0, 1, 64'h41, 0, 0, 0);
    drive(0, 0, 64'd0, 1, 0, 0);
    idle(2);
    drive(0, 1, 64'h42, 0, 0, 0);
    idle(2);
    drive(0, 0, 64'd0, 1, 0, 0);
    idle(8);

    // reset with entries pending while stalled
    for (int j = 0; j < 3; j++) drive(0, 1, 64'h50 + 64'(j), 0, 0, 0);
    drive(0, 1, 64'h99, 1, 1, 0);
    drive(1, 1, 64'h77, 1, 0, 1);
    idle(3);

    // randomized traffic
    for (int j = 0; j < 3000; j++) begin
      int  phase;
      bit  r, i, a, m, c;
      phase = (j / 250) % 4;
      r = ($urandom_range(0, 299) == 0);
      case (phase)
        0: begin i = ($urandom_range(0, 3) == 0); a = ($urandom_range(0, 1) == 0); end
        1: begin i = ($urandom_range(0, 3) != 0); a = ($urandom_range(0, 4) == 0); end
        2: begin i = ($urandom_range(0, 1) == 0); a = ($urandom_range(0, 1) == 0); end
        default: begin i = ($urandom_range(0, 9) == 0); a = ($urandom_range(0, 2) != 0); end
      endcase
      m = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 15) == 0);
      drive(r, i, {$urandom, $urandom}, a, m, c);
    end
    idle(2);

    @(posedge clk);
    #2;
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
